// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
// Shared encodings and helpers for the MEM stage:
//   - access size encodings (byte / half / word / dword)
//   - FSM state encodings (idle / waiting on memory)
//   - be_mask():    byte-enable mask for a given size and byte lane
//   - align_mask(): lane bits that must be zero for an aligned access
package mem_stage_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } mem_size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  // Mask is sized for the widest (64-bit) datapath; narrower users truncate it.
  function automatic logic [7:0] be_mask(input logic [1:0] size, input logic [2:0] lane);
    logic [7:0] base;
    case (size)
      SZ_BYTE: base = 8'h01;
      SZ_HALF: base = 8'h03;
      SZ_WORD: base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << lane;
  endfunction

  function automatic logic [2:0] align_mask(input logic [1:0] size);
    logic [2:0] m;
    case (size)
      SZ_BYTE: m = 3'b000;
      SZ_HALF: m = 3'b001;
      SZ_WORD: m = 3'b011;
      default: m = 3'b111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if
// Bundles the EX/MEM inputs, the MEM/WB outputs, branch resolution, stall
// handshake and debug read port of the MEM stage.
//   master: upstream pipeline / test driver (drives in_*, reads results)
//   slave : mem_access_stage
interface mem_access_stage_if #(
  parameter int LEN_DATA   = 32,
  parameter int NUM_BITS   = 5,
  parameter int LEN_WB_BUS = 2,
  parameter int RAM_DEPTH  = 2048
);
  localparam int ADDR_W = $clog2(RAM_DEPTH);

  logic                  in_valid;
  logic [LEN_DATA-1:0]   in_addr_mem;
  logic [LEN_DATA-1:0]   write_data;
  logic                  mem_read;
  logic                  mem_write;
  logic [1:0]            mem_size;
  logic                  mem_unsigned;
  logic                  branch;
  logic                  branch_ne;
  logic                  zero_flag;
  logic [LEN_DATA-1:0]   in_pc_branch;
  logic [LEN_WB_BUS-1:0] in_writeBack_bus;
  logic [NUM_BITS-1:0]   in_write_reg;
  logic                  halt_flag_m;
  logic [ADDR_W-1:0]     dbg_addr;

  logic                  stall;
  logic                  pc_src;
  logic [LEN_DATA-1:0]   out_pc_branch;
  logic                  out_valid;
  logic [LEN_DATA-1:0]   read_data;
  logic [LEN_DATA-1:0]   out_addr_mem;
  logic [LEN_WB_BUS-1:0] out_writeBack_bus;
  logic [NUM_BITS-1:0]   out_write_reg;
  logic                  out_halt_flag_m;
  logic                  misalign_exc;
  logic [LEN_DATA-1:0]   dbg_data;

  modport master (
    output in_valid, in_addr_mem, write_data, mem_read, mem_write, mem_size,
           mem_unsigned, branch, branch_ne, zero_flag, in_pc_branch,
           in_writeBack_bus, in_write_reg, halt_flag_m, dbg_addr,
    input  stall, pc_src, out_pc_branch, out_valid, read_data, out_addr_mem,
           out_writeBack_bus, out_write_reg, out_halt_flag_m, misalign_exc, dbg_data
  );

  modport slave (
    input  in_valid, in_addr_mem, write_data, mem_read, mem_write, mem_size,
           mem_unsigned, branch, branch_ne, zero_flag, in_pc_branch,
           in_writeBack_bus, in_write_reg, halt_flag_m, dbg_addr,
    output stall, pc_src, out_pc_branch, out_valid, read_data, out_addr_mem,
           out_writeBack_bus, out_write_reg, out_halt_flag_m, misalign_exc, dbg_data
  );

endinterface

// File: rtl/byte_en_ram.sv
// byte_en_ram
// Single-port data memory with per-byte write enables and a registered read,
// plus an asynchronous debug read port. Contents are never reset.
//   clk        : clock
//   i_addr     : word index for the read/write port
//   i_we       : one write enable per byte lane
//   i_wdata    : write data (already lane-replicated by the caller)
//   i_re       : capture the read word on this edge
//   o_rdata    : registered read word (value before any same-edge write)
//   i_dbg_addr : debug word index
//   o_dbg_data : asynchronous debug read
module byte_en_ram #(
  parameter int LEN_DATA  = 32,
  parameter int RAM_DEPTH = 2048
) (
  input  logic                         clk,
  input  logic [$clog2(RAM_DEPTH)-1:0] i_addr,
  input  logic [LEN_DATA/8-1:0]        i_we,
  input  logic [LEN_DATA-1:0]          i_wdata,
  input  logic                         i_re,
  output logic [LEN_DATA-1:0]          o_rdata,
  input  logic [$clog2(RAM_DEPTH)-1:0] i_dbg_addr,
  output logic [LEN_DATA-1:0]          o_dbg_data
);
  localparam int NB = LEN_DATA / 8;

  logic [LEN_DATA-1:0] r_mem [RAM_DEPTH];
  logic [LEN_DATA-1:0] r_rdata;

  // Byte-granular write; the read captures the old word, so a combined
  // read+write on one edge returns the pre-write data.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (i_we[b]) begin
        r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
    if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata    = r_rdata;
  assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage
// MIPS MEM stage plus MEM/WB register. Performs byte-lane-correct sub-word
// loads/stores against a latency-configurable data memory, flags misaligned
// accesses, stalls upstream while an access is in flight, and resolves
// branches combinationally.
//   clk, reset : clock, synchronous active-high reset
//   bus        : mem_access_stage_if slave (EX/MEM inputs, MEM/WB outputs,
//                branch result, stall, debug read)
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int LEN_DATA    = 32,
  parameter int NUM_BITS    = 5,
  parameter int LEN_WB_BUS  = 2,
  parameter int RAM_DEPTH   = 2048,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  mem_access_stage_if.slave bus
);
  localparam int         NB     = LEN_DATA / 8;
  localparam int         LANE_W = $clog2(NB);
  localparam int         ADDR_W = $clog2(RAM_DEPTH);
  localparam logic [2:0] LAT    = 3'(MEM_LATENCY);

  logic [LANE_W-1:0]     w_lane;
  logic [2:0]            w_laneExt;
  logic [ADDR_W-1:0]     w_wordIdx;
  logic                  w_isMem;
  logic                  w_illegal;
  logic                  w_misalign;
  logic                  w_issue;
  logic [NB-1:0]         w_beMask;
  logic [NB-1:0]         w_we;
  logic                  w_re;
  logic [LEN_DATA-1:0]   w_wdata;
  logic [LEN_DATA-1:0]   w_rdata;
  logic [LEN_DATA-1:0]   w_shifted;
  logic [LEN_DATA-1:0]   w_loadData;
  logic                  w_signBit;

  mem_state_e            r_state;
  mem_state_e            w_stateNext;
  logic [2:0]            r_count;
  logic [2:0]            w_countNext;
  logic                  w_stall;
  logic                  w_memIssue;

  logic                  r_outValid;
  logic [LEN_DATA-1:0]   r_readData;
  logic [LEN_DATA-1:0]   r_addrMem;
  logic [LEN_WB_BUS-1:0] r_wbBus;
  logic [NUM_BITS-1:0]   r_writeReg;
  logic                  r_halt;
  logic                  r_misalign;

  assign w_lane    = bus.in_addr_mem[LANE_W-1:0];
  assign w_laneExt = 3'(w_lane);
  // Address bits above the RAM index are dropped, so addresses wrap.
  assign w_wordIdx = bus.in_addr_mem[LANE_W +: ADDR_W];
  assign w_isMem   = bus.in_valid & (bus.mem_read | bus.mem_write);
  // A dword on a 32-bit datapath cannot be served; treat it as misaligned.
  assign w_illegal = (bus.mem_size == SZ_DWORD) && (LEN_DATA == 32);
  assign w_misalign = w_isMem &
                      (w_illegal | ((w_laneExt & align_mask(bus.mem_size)) != 3'd0));
  assign w_issue   = w_isMem & ~w_misalign & ~reset;
  assign w_beMask  = NB'(be_mask(bus.mem_size, w_laneExt));
  assign w_we      = (w_memIssue & bus.mem_write) ? w_beMask : '0;
  assign w_re      = w_memIssue & bus.mem_read;

  // Replicate the low bytes of the store data across every lane so the
  // byte enables alone pick the right position.
  always_comb begin
    w_wdata = bus.write_data;
    case (bus.mem_size)
      SZ_BYTE: w_wdata = {(LEN_DATA/8){bus.write_data[7:0]}};
      SZ_HALF: w_wdata = {(LEN_DATA/16){bus.write_data[15:0]}};
      SZ_WORD: w_wdata = {(LEN_DATA/32){bus.write_data[31:0]}};
      default: w_wdata = bus.write_data;
    endcase
  end

  byte_en_ram #(
    .LEN_DATA  (LEN_DATA),
    .RAM_DEPTH (RAM_DEPTH)
  ) u_ram (
    .clk        (clk),
    .i_addr     (w_wordIdx),
    .i_we       (w_we),
    .i_wdata    (w_wdata),
    .i_re       (w_re),
    .o_rdata    (w_rdata),
    .i_dbg_addr (bus.dbg_addr),
    .o_dbg_data (bus.dbg_data)
  );

  // Bring the accessed lanes down to bit 0, then extend. Word/dword are
  // only masked, never sign-extended.
  always_comb begin
    w_shifted  = w_rdata >> {w_lane, 3'b000};
    w_signBit  = 1'b0;
    w_loadData = w_shifted;
    case (bus.mem_size)
      SZ_BYTE: begin
        w_signBit  = ~bus.mem_unsigned & w_shifted[7];
        w_loadData = LEN_DATA'(w_shifted[7:0]) | ({LEN_DATA{w_signBit}} << 8);
      end
      SZ_HALF: begin
        w_signBit  = ~bus.mem_unsigned & w_shifted[15];
        w_loadData = LEN_DATA'(w_shifted[15:0]) | ({LEN_DATA{w_signBit}} << 16);
      end
      SZ_WORD: w_loadData = LEN_DATA'(w_shifted[31:0]);
      default: w_loadData = w_shifted;
    endcase
  end

  // FSM state and wait counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_count <= 3'd0;
    end else begin
      r_state <= w_stateNext;
      r_count <= w_countNext;
    end
  end

  // Next state: an aligned access parks the FSM in WAIT for MEM_LATENCY cycles.
  always_comb begin
    w_stateNext = r_state;
    w_countNext = r_count;
    case (r_state)
      ST_IDLE: begin
        if (w_issue) begin
          w_stateNext = ST_WAIT;
          w_countNext = LAT;
        end
      end
      ST_WAIT: begin
        if (r_count > 3'd1) begin
          w_countNext = r_count - 3'd1;
        end else begin
          w_stateNext = ST_IDLE;
          w_countNext = 3'd0;
        end
      end
      default: begin
        w_stateNext = ST_IDLE;
        w_countNext = 3'd0;
      end
    endcase
  end

  // Outputs: the memory port fires only in the issue cycle, so a held store
  // is written exactly once. The last WAIT cycle drops stall to release upstream.
  always_comb begin
    w_stall    = 1'b0;
    w_memIssue = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_stall    = w_issue;
        w_memIssue = w_issue;
      end
      ST_WAIT: w_stall = ~reset & (r_count > 3'd1);
      default: w_stall = 1'b0;
    endcase
  end

  // MEM/WB register: a bubble while stalled, otherwise capture the current
  // instruction (pass-through, misaligned, or completing access).
  always_ff @(posedge clk) begin
    if (reset || w_stall) begin
      r_outValid <= 1'b0;
      r_readData <= '0;
      r_addrMem  <= '0;
      r_wbBus    <= '0;
      r_writeReg <= '0;
      r_halt     <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_outValid <= bus.in_valid;
      r_readData <= (r_state == ST_WAIT && bus.mem_read) ? w_loadData : '0;
      r_addrMem  <= bus.in_addr_mem;
      r_wbBus    <= w_misalign ? '0 : bus.in_writeBack_bus;
      r_writeReg <= bus.in_write_reg;
      r_halt     <= bus.halt_flag_m;
      r_misalign <= w_misalign;
    end
  end

  assign bus.stall             = w_stall;
  assign bus.pc_src            = bus.in_valid & bus.branch &
                                 (bus.branch_ne ? ~bus.zero_flag : bus.zero_flag);
  assign bus.out_pc_branch     = bus.in_pc_branch;
  assign bus.out_valid         = r_outValid;
  assign bus.read_data         = r_readData;
  assign bus.out_addr_mem      = r_addrMem;
  assign bus.out_writeBack_bus = r_wbBus;
  assign bus.out_write_reg     = r_writeReg;
  assign bus.out_halt_flag_m   = r_halt;
  assign bus.misalign_exc      = r_misalign;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage
// Directed bench for mem_access_stage (32-bit datapath, 256 words, latency 3).
module tb_mem_access_stage;
  import mem_stage_pkg::*;

  localparam int LEN_DATA    = 32;
  localparam int NUM_BITS    = 5;
  localparam int LEN_WB_BUS  = 2;
  localparam int RAM_DEPTH   = 256;
  localparam int MEM_LATENCY = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int compared = 0;
  int mismatched = 0;

  mem_access_stage_if #(
    .LEN_DATA(LEN_DATA), .NUM_BITS(NUM_BITS),
    .LEN_WB_BUS(LEN_WB_BUS), .RAM_DEPTH(RAM_DEPTH)
  ) bus ();

  mem_access_stage #(
    .LEN_DATA(LEN_DATA), .NUM_BITS(NUM_BITS), .LEN_WB_BUS(LEN_WB_BUS),
    .RAM_DEPTH(RAM_DEPTH), .MEM_LATENCY(MEM_LATENCY)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic rd, input logic wr,
                               input logic [1:0] sz, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [1:0] wb, input logic [4:0] wreg,
                               input logic halt);
    bus.in_valid         = v;
    bus.mem_read         = rd;
    bus.mem_write        = wr;
    bus.mem_size         = sz;
    bus.mem_unsigned     = uns;
    bus.in_addr_mem      = addr;
    bus.write_data       = wdata;
    bus.in_writeBack_bus = wb;
    bus.in_write_reg     = wreg;
    bus.halt_flag_m      = halt;
    bus.branch           = 1'b0;
    bus.branch_ne        = 1'b0;
    bus.zero_flag        = 1'b0;
    bus.in_pc_branch     = 32'h0;
  endtask

  // Holds the applied inputs until the stage releases them; returns the
  // number of stalled cycles and leaves the bench just after the capture edge.
  task automatic runInstr(output int stallCycles);
    stallCycles = 0;
    #1;
    while (bus.stall === 1'b1 && stallCycles < 20) begin
      stallCycles++;
      @(posedge clk);
      #2;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int n;
    applyStimulus(1, 1, 0, SZ_WORD, 0, 32'h100, 32'h0, 2'b01, 5'd1, 1);
    bus.dbg_addr = '0;
    tick();
    compared++;
    if (bus.stall !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_stall: got %b expected 0", bus.stall);
    end
    tick();
    compared++;
    if ({bus.out_valid, bus.misalign_exc, bus.out_halt_flag_m, bus.out_writeBack_bus,
         bus.out_write_reg} !== 10'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_ctrl: got v=%b mis=%b halt=%b wb=%b reg=%0d expected all 0",
               bus.out_valid, bus.misalign_exc, bus.out_halt_flag_m, bus.out_writeBack_bus,
               bus.out_write_reg);
    end
    compared++;
    if (bus.read_data !== 32'h0 || bus.out_addr_mem !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_data: got rd=%h addr=%h expected 0/0", bus.read_data, bus.out_addr_mem);
    end
    reset = 1'b0;
    applyStimulus(0, 0, 0, SZ_WORD, 0, 32'h0, 32'h0, 2'b00, 5'd0, 0);
    runInstr(n);
  endtask

  task automatic test_store_load();
    int n;
    applyStimulus(1, 0, 1, SZ_WORD, 0, 32'h100, 32'h1122_3344, 2'b00, 5'd0, 0);
    runInstr(n);
    compared++;
    if (n !== MEM_LATENCY) begin
      mismatched++;
      $display("[TB] FAIL sw_stall_cycles: got %0d expected %0d", n, MEM_LATENCY);
    end
    compared++;
    if (bus.out_valid !== 1'b1 || bus.read_data !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL sw_complete: got v=%b rd=%h expected 1/00000000", bus.out_valid, bus.read_data);
    end
    applyStimulus(1, 0, 1, SZ_BYTE, 0, 32'h103, 32'hABCD_12F0, 2'b00, 5'd0, 0);
    runInstr(n);
    bus.dbg_addr = 8'h40;
    #1;
    compared++;
    if (bus.dbg_data !== 32'hF022_3344) begin
      mismatched++;
      $display("[TB] FAIL sb_lanes: got %h expected F0223344", bus.dbg_data);
    end
    applyStimulus(1, 1, 0, SZ_BYTE, 1, 32'h103, 32'h0, 2'b11, 5'd7, 0);
    runInstr(n);
    compared++;
    if (bus.read_data !== 32'h0000_00F0) begin
      mismatched++;
      $display("[TB] FAIL lbu_data: got %h expected 000000F0", bus.read_data);
    end
    compared++;
    if (bus.out_write_reg !== 5'd7 || bus.out_writeBack_bus !== 2'b11 || bus.out_addr_mem !== 32'h103) begin
      mismatched++;
      $display("[TB] FAIL lbu_ctrl: got reg=%0d wb=%b addr=%h expected 7/11/00000103",
               bus.out_write_reg, bus.out_writeBack_bus, bus.out_addr_mem);
    end
    applyStimulus(1, 1, 0, SZ_BYTE, 0, 32'h103, 32'h0, 2'b11, 5'd7, 0);
    runInstr(n);
    compared++;
    if (bus.read_data !== 32'hFFFF_FFF0) begin
      mismatched++;
      $display("[TB] FAIL lb_data: got %h expected FFFFFFF0", bus.read_data);
    end
    applyStimulus(1, 1, 0, SZ_HALF, 0, 32'h102, 32'h0, 2'b11, 5'd7, 0);
    runInstr(n);
    compared++;
    if (bus.read_data !== 32'hFFFF_F022) begin
      mismatched++;
      $display("[TB] FAIL lh_data: got %h expected FFFFF022", bus.read_data);
    end
    applyStimulus(1, 1, 0, SZ_HALF, 1, 32'h100, 32'h0, 2'b11, 5'd7, 0);
    runInstr(n);
    compared++;
    if (bus.read_data !== 32'h0000_3344) begin
      mismatched++;
      $display("[TB] FAIL lhu_data: got %h expected 00003344", bus.read_data);
    end
    applyStimulus(1, 1, 0, SZ_WORD, 0, 32'h100, 32'h0, 2'b11, 5'd7, 0);
    runInstr(n);
    compared++;
    if (bus.read_data !== 32'hF022_3344) begin
      mismatched++;
      $display("[TB] FAIL lw_data: got %h expected F0223344", bus.read_data);
    end
    applyStimulus(1, 0, 1, SZ_WORD, 0, 32'h104, 32'h5566_7788, 2'b00, 5'd0, 0);
    runInstr(n);
    applyStimulus(1, 0, 1, SZ_HALF, 0, 32'h106, 32'hCAFE_BEEF, 2'b00, 5'd0, 0);
    runInstr(n);
    bus.dbg_addr = 8'h41;
    #1;
    compared++;
    if (bus.dbg_data !== 32'hBEEF_7788) begin
      mismatched++;
      $display("[TB] FAIL sh_lanes: got %h expected BEEF7788", bus.dbg_data);
    end
    applyStimulus(1, 1, 0, SZ_BYTE, 0, 32'h105, 32'h0, 2'b11, 5'd7, 0);
    runInstr(n);
    compared++;
    if (bus.read_data !== 32'h0000_0077) begin
      mismatched++;
      $display("[TB] FAIL lb_positive: got %h expected 00000077", bus.read_data);
    end
  endtask

  task automatic test_read_write_both();
    int n;
    applyStimulus(1, 1, 1, SZ_WORD, 0, 32'h100, 32'h9999_9999, 2'b01, 5'd2, 0);
    runInstr(n);
    compared++;
    if (bus.read_data !== 32'hF022_3344) begin
      mismatched++;
      $display("[TB] FAIL rw_prewrite: got %h expected F0223344", bus.read_data);
    end
    bus.dbg_addr = 8'h40;
    #1;
    compared++;
    if (bus.dbg_data !== 32'h9999_9999) begin
      mismatched++;
      $display("[TB] FAIL rw_store: got %h expected 99999999", bus.dbg_data);
    end
  endtask

  task automatic test_latency();
    applyStimulus(1, 1, 0, SZ_WORD, 0, 32'h100, 32'h0, 2'b01, 5'd3, 1);
    #1;
    compared++;
    if (bus.stall !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL lat_issue_stall: got %b expected 1", bus.stall);
    end
    for (int i = 1; i <= 3; i++) begin
      tick();
      #1;
      compared++;
      if (bus.stall !== (i < 3) || bus.out_valid !== 1'b0 || bus.out_halt_flag_m !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL lat_wait_%0d: got stall=%b v=%b halt=%b expected %b/0/0",
                 i, bus.stall, bus.out_valid, bus.out_halt_flag_m, (i < 3));
      end
    end
    tick();
    compared++;
    if (bus.out_valid !== 1'b1 || bus.read_data !== 32'h9999_9999 || bus.out_halt_flag_m !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL lat_result: got v=%b rd=%h halt=%b expected 1/99999999/1",
               bus.out_valid, bus.read_data, bus.out_halt_flag_m);
    end
    applyStimulus(1, 0, 0, SZ_WORD, 0, 32'h1234, 32'h0, 2'b10, 5'd9, 0);
    #1;
    compared++;
    if (bus.stall !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL add_stall: got %b expected 0", bus.stall);
    end
    tick();
    compared++;
    if (bus.out_valid !== 1'b1 || bus.out_addr_mem !== 32'h1234 || bus.read_data !== 32'h0 ||
        bus.out_writeBack_bus !== 2'b10 || bus.out_write_reg !== 5'd9) begin
      mismatched++;
      $display("[TB] FAIL add_result: got v=%b addr=%h rd=%h wb=%b reg=%0d expected 1/00001234/0/10/9",
               bus.out_valid, bus.out_addr_mem, bus.read_data, bus.out_writeBack_bus, bus.out_write_reg);
    end
    applyStimulus(1, 0, 0, SZ_WORD, 0, 32'h5678, 32'h0, 2'b10, 5'd10, 0);
    tick();
    compared++;
    if (bus.out_write_reg !== 5'd10 || bus.out_addr_mem !== 32'h5678) begin
      mismatched++;
      $display("[TB] FAIL back_to_back: got reg=%0d addr=%h expected 10/00005678",
               bus.out_write_reg, bus.out_addr_mem);
    end
    applyStimulus(0, 0, 0, SZ_WORD, 0, 32'h0, 32'h0, 2'b10, 5'd11, 0);
    tick();
    compared++;
    if (bus.out_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL invalid_passthru: got %b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_misalign();
    int n;
    applyStimulus(1, 0, 1, SZ_WORD, 0, 32'h200, 32'hDEAD_BEEF, 2'b00, 5'd0, 0);
    runInstr(n);
    applyStimulus(1, 1, 0, SZ_HALF, 0, 32'h201, 32'h0, 2'b11, 5'd4, 0);
    #1;
    compared++;
    if (bus.stall !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL lh_mis_stall: got %b expected 0", bus.stall);
    end
    tick();
    compared++;
    if (bus.misalign_exc !== 1'b1 || bus.out_writeBack_bus !== 2'b00 ||
        bus.read_data !== 32'h0 || bus.out_valid !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL lh_mis_result: got mis=%b wb=%b rd=%h v=%b expected 1/00/0/1",
               bus.misalign_exc, bus.out_writeBack_bus, bus.read_data, bus.out_valid);
    end
    applyStimulus(1, 0, 1, SZ_WORD, 0, 32'h202, 32'h0102_0304, 2'b00, 5'd0, 0);
    #1;
    compared++;
    if (bus.stall !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL sw_mis_stall: got %b expected 0", bus.stall);
    end
    tick();
    bus.dbg_addr = 8'h80;
    #1;
    compared++;
    if (bus.misalign_exc !== 1'b1 || bus.dbg_data !== 32'hDEAD_BEEF) begin
      mismatched++;
      $display("[TB] FAIL sw_mis_mem: got mis=%b mem=%h expected 1/DEADBEEF", bus.misalign_exc, bus.dbg_data);
    end
    applyStimulus(1, 1, 0, SZ_WORD, 0, 32'h200, 32'h0, 2'b01, 5'd5, 0);
    runInstr(n);
    compared++;
    if (n !== MEM_LATENCY || bus.misalign_exc !== 1'b0 || bus.read_data !== 32'hDEAD_BEEF) begin
      mismatched++;
      $display("[TB] FAIL lw_aligned: got stalls=%0d mis=%b rd=%h expected 3/0/DEADBEEF",
               n, bus.misalign_exc, bus.read_data);
    end
  endtask

  task automatic test_branch();
    int n;
    applyStimulus(1, 0, 0, SZ_WORD, 0, 32'h0, 32'h0, 2'b00, 5'd0, 0);
    bus.in_pc_branch = 32'h0000_4444;
    bus.branch = 1'b1; bus.branch_ne = 1'b1; bus.zero_flag = 1'b0;
    #1;
    compared++;
    if (bus.pc_src !== 1'b1 || bus.out_pc_branch !== 32'h0000_4444) begin
      mismatched++;
      $display("[TB] FAIL bne_taken: got pc_src=%b tgt=%h expected 1/00004444", bus.pc_src, bus.out_pc_branch);
    end
    bus.in_valid = 1'b0;
    #1;
    compared++;
    if (bus.pc_src !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL bne_invalid: got %b expected 0", bus.pc_src);
    end
    bus.in_valid = 1'b1; bus.branch_ne = 1'b0; bus.zero_flag = 1'b1;
    #1;
    compared++;
    if (bus.pc_src !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL beq_taken: got %b expected 1", bus.pc_src);
    end
    bus.zero_flag = 1'b0;
    #1;
    compared++;
    if (bus.pc_src !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL beq_not_taken: got %b expected 0", bus.pc_src);
    end
    tick();
    applyStimulus(1, 1, 0, SZ_WORD, 0, 32'h200, 32'h0, 2'b00, 5'd0, 0);
    bus.branch = 1'b1; bus.branch_ne = 1'b0; bus.zero_flag = 1'b1;
    #1;
    compared++;
    if (bus.stall !== 1'b1 || bus.pc_src !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL branch_during_stall: got stall=%b pc_src=%b expected 1/1", bus.stall, bus.pc_src);
    end
    runInstr(n);
  endtask

  task automatic test_reset_wait();
    applyStimulus(1, 0, 1, SZ_WORD, 0, 32'h40, 32'h1234_5678, 2'b00, 5'd0, 0);
    tick();
    tick();
    #1;
    compared++;
    if (bus.stall !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL rstwait_pre: got %b expected 1", bus.stall);
    end
    reset = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    compared++;
    if (bus.stall !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL rstwait_cycle_stall: got %b expected 0", bus.stall);
    end
    tick();
    reset = 1'b0;
    bus.dbg_addr = 8'h10;
    #1;
    compared++;
    if (bus.stall !== 1'b0 || bus.out_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL rstwait_after: got stall=%b v=%b expected 0/0", bus.stall, bus.out_valid);
    end
    compared++;
    if (bus.dbg_data !== 32'h1234_5678) begin
      mismatched++;
      $display("[TB] FAIL rstwait_mem: got %h expected 12345678", bus.dbg_data);
    end
    tick();
  endtask

  task automatic test_addr_wrap();
    int n;
    applyStimulus(1, 0, 1, SZ_WORD, 0, RAM_DEPTH*4 + 8, 32'hA5A5_5A5A, 2'b00, 5'd0, 0);
    runInstr(n);
    bus.dbg_addr = 8'd2;
    #1;
    compared++;
    if (bus.dbg_data !== 32'hA5A5_5A5A) begin
      mismatched++;
      $display("[TB] FAIL wrap_store: got %h expected A5A55A5A", bus.dbg_data);
    end
    applyStimulus(1, 1, 0, SZ_WORD, 0, 32'h8, 32'h0, 2'b01, 5'd6, 0);
    runInstr(n);
    compared++;
    if (bus.read_data !== 32'hA5A5_5A5A) begin
      mismatched++;
      $display("[TB] FAIL wrap_load: got %h expected A5A55A5A", bus.read_data);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_read_write_both();
    test_latency();
    test_misalign();
    test_branch();
    test_reset_wait();
    test_addr_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
